// File: rtl/fb_mem_responder.sv
// Memory-side responder for the FB CPU bus: single-port word memory, program
// loader that holds the CPU in reset while filling memory, and one memory-mapped output register.
module fb_mem_responder #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int IO_ADDR       = 63
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] MAR,
    input  logic                     RAMWr,
    input  logic [DATA_WIDTH-1:0]    MDRIn,
    output logic [DATA_WIDTH-1:0]    MDROut,
    input  logic                     ld_valid,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_last,
    output logic                     ld_ready,
    input  logic                     ld_start,
    output logic                     cpu_rst,
    output logic [DATA_WIDTH-1:0]    io_out,
    output logic                     io_strobe
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] PTR_MAX   = {ADDRESS_WIDTH{1'b1}};
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ZERO  = {ADDRESS_WIDTH{1'b0}};
    localparam logic [ADDRESS_WIDTH-1:0] IO_ADDR_C = ADDRESS_WIDTH'(IO_ADDR);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [ADDRESS_WIDTH-1:0] ptr_r;
    logic [ADDRESS_WIDTH-1:0] ptr_nxt_s;
    logic                     cpu_rst_r;
    logic                     ld_ready_r;

    logic                     we_s;
    logic [ADDRESS_WIDTH-1:0] waddr_s;
    logic [DATA_WIDTH-1:0]    wdata_s;
    logic                     io_hit_s;

    logic [DATA_WIDTH-1:0]    mem_r [0:DEPTH-1];

    // Next-state, loader pointer and the single memory write port selection.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        we_s        = 1'b0;
        waddr_s     = ptr_r;
        wdata_s     = ld_data;
        io_hit_s    = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (ld_valid) begin
                    we_s    = 1'b1;
                    waddr_s = ptr_r;
                    wdata_s = ld_data;
                    // The pointer saturates at the top address; the load ends there.
                    if (ld_last || (ptr_r == PTR_MAX)) begin
                        state_nxt_s = ST_RELEASE;
                    end else begin
                        ptr_nxt_s = ptr_r + ADDRESS_WIDTH'(1);
                    end
                end else begin
                    we_s = 1'b0;
                end
            end
            ST_RELEASE: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (RAMWr) begin
                    we_s     = 1'b1;
                    waddr_s  = MAR;
                    wdata_s  = MDRIn;
                    io_hit_s = (MAR == IO_ADDR_C);
                end else begin
                    we_s = 1'b0;
                end
                if (ld_start) begin
                    state_nxt_s = ST_LOAD;
                    ptr_nxt_s   = PTR_ZERO;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
                ptr_nxt_s   = PTR_ZERO;
            end
        endcase
    end

    // Control state, registered handshake/reset outputs, read data and IO register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_LOAD;
            ptr_r      <= PTR_ZERO;
            cpu_rst_r  <= 1'b1;
            ld_ready_r <= 1'b1;
            MDROut     <= {DATA_WIDTH{1'b0}};
            io_out     <= {DATA_WIDTH{1'b0}};
            io_strobe  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            cpu_rst_r  <= (state_nxt_s != ST_RUN);
            ld_ready_r <= (state_nxt_s == ST_LOAD);
            MDROut     <= mem_r[MAR];
            io_strobe  <= io_hit_s;
            if (io_hit_s) begin
                io_out <= MDRIn;
            end
        end
    end

    // Memory write port; the read above sees the pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (!rst && we_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Reset forces the CPU into reset and stalls the loader within the same cycle.
    assign cpu_rst  = cpu_rst_r | rst;
    assign ld_ready = ld_ready_r & ~rst;

endmodule

// File: tb/tb_fb_mem_responder.sv
// Directed self-checking bench for fb_mem_responder: load, read latency,
// read-first writes, IO register, full load without wrap, reload and mid-load reset.
module tb_fb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] MAR;
    logic       RAMWr;
    logic [9:0] MDRIn;
    logic [9:0] MDROut;
    logic       ld_valid;
    logic [9:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       ld_start;
    logic       cpu_rst;
    logic [9:0] io_out;
    logic       io_strobe;

    int total = 0;
    int bad   = 0;

    fb_mem_responder #(
        .ADDRESS_WIDTH(6),
        .DATA_WIDTH   (10),
        .IO_ADDR      (63)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MAR      (MAR),
        .RAMWr    (RAMWr),
        .MDRIn    (MDRIn),
        .MDROut   (MDROut),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_start (ld_start),
        .cpu_rst  (cpu_rst),
        .io_out   (io_out),
        .io_strobe(io_strobe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0] words [0:2];
        words[0] = 10'h000;
        words[1] = 10'h1C5;
        words[2] = 10'h3FF;

        rst = 1'b1; MAR = 6'd0; RAMWr = 1'b0; MDRIn = 10'h000;
        ld_valid = 1'b0; ld_data = 10'h000; ld_last = 1'b0; ld_start = 1'b0;
        #1;
        chk("rst_cpu_rst_comb", 16'(cpu_rst), 16'h1);
        chk("rst_ld_ready_comb", 16'(ld_ready), 16'h0);
        tick();
        tick();
        chk("rst_mdrout", 16'(MDROut), 16'h000);
        chk("rst_io_out", 16'(io_out), 16'h000);
        chk("rst_io_strobe", 16'(io_strobe), 16'h0);
        chk("rst_cpu_rst", 16'(cpu_rst), 16'h1);
        chk("rst_ld_ready", 16'(ld_ready), 16'h0);

        // First load: three words, last flagged on the third.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = words[i];
            ld_last  = (i == 2);
            chk("load3_ld_ready", 16'(ld_ready), 16'h1);
            chk("load3_cpu_rst", 16'(cpu_rst), 16'h1);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("release_ld_ready", 16'(ld_ready), 16'h0);
        chk("release_cpu_rst", 16'(cpu_rst), 16'h1);
        tick();
        chk("run_cpu_rst", 16'(cpu_rst), 16'h0);
        chk("run_ld_ready", 16'(ld_ready), 16'h0);

        // Read latency: MDROut follows MAR one cycle later.
        MAR = 6'd1; tick(); chk("rd_mar1", 16'(MDROut), 16'h1C5);
        MAR = 6'd0; tick(); chk("rd_mar0", 16'(MDROut), 16'h000);
        MAR = 6'd2; tick(); chk("rd_mar2", 16'(MDROut), 16'h3FF);
        MAR = 6'd1; tick(); chk("rd_mar1b", 16'(MDROut), 16'h1C5);

        // Read-first write behaviour.
        MAR = 6'd5; RAMWr = 1'b1; MDRIn = 10'h0AB; tick();
        MDRIn = 10'h2AA; tick();
        chk("wr_read_first", 16'(MDROut), 16'h0AB);
        chk("wr_no_strobe", 16'(io_strobe), 16'h0);
        RAMWr = 1'b0; tick();
        chk("wr_new_value", 16'(MDROut), 16'h2AA);

        // IO register stores.
        MAR = 6'd63; RAMWr = 1'b1; MDRIn = 10'h155; tick();
        chk("io_out_155", 16'(io_out), 16'h155);
        chk("io_strobe_1", 16'(io_strobe), 16'h1);
        RAMWr = 1'b0; tick();
        chk("io_strobe_drop", 16'(io_strobe), 16'h0);
        chk("io_mem63", 16'(MDROut), 16'h155);
        chk("io_out_hold", 16'(io_out), 16'h155);
        RAMWr = 1'b1; MDRIn = 10'h0F0; tick();
        chk("io_b2b_strobe_a", 16'(io_strobe), 16'h1);
        chk("io_b2b_out_a", 16'(io_out), 16'h0F0);
        MDRIn = 10'h00F; tick();
        chk("io_b2b_strobe_b", 16'(io_strobe), 16'h1);
        chk("io_b2b_out_b", 16'(io_out), 16'h00F);
        MAR = 6'd62; MDRIn = 10'h111; tick();
        chk("io62_no_strobe", 16'(io_strobe), 16'h0);
        chk("io62_out_hold", 16'(io_out), 16'h00F);
        RAMWr = 1'b0; tick();
        chk("mem62", 16'(MDROut), 16'h111);

        // Reload request; a store in the same cycle is still serviced.
        ld_start = 1'b1; MAR = 6'd4; RAMWr = 1'b1; MDRIn = 10'h044; tick();
        chk("reload_cpu_rst", 16'(cpu_rst), 16'h1);
        chk("reload_ld_ready", 16'(ld_ready), 16'h1);
        ld_start = 1'b0;
        MAR = 6'd5; MDRIn = 10'h3C3; tick();
        RAMWr = 1'b0; tick();
        chk("load_store_ignored", 16'(MDROut), 16'h2AA);
        MAR = 6'd4; tick();
        chk("ld_start_cycle_store", 16'(MDROut), 16'h044);

        // Full 64-word load without ld_last; no wrap back to address 0.
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1'b1;
            ld_data  = 10'h200 | 10'(i);
            tick();
        end
        chk("full_release_ld_ready", 16'(ld_ready), 16'h0);
        chk("full_release_cpu_rst", 16'(cpu_rst), 16'h1);
        ld_data = 10'h3EE;
        tick();
        ld_valid = 1'b0;
        chk("full_run_cpu_rst", 16'(cpu_rst), 16'h0);
        MAR = 6'd0;  tick(); chk("full_mem0", 16'(MDROut), 16'h200);
        MAR = 6'd63; tick(); chk("full_mem63", 16'(MDROut), 16'h23F);
        MAR = 6'd5;  tick(); chk("full_mem5", 16'(MDROut), 16'h205);
        chk("full_io_out_hold", 16'(io_out), 16'h00F);

        // Mid-load reset: two of four words, then reset aborts the load.
        ld_start = 1'b1; tick();
        ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 10'h0A1; tick();
        ld_data = 10'h0A2; tick();
        rst = 1'b1; ld_data = 10'h0A3; tick();
        chk("midrst_io_out", 16'(io_out), 16'h000);
        chk("midrst_cpu_rst", 16'(cpu_rst), 16'h1);
        chk("midrst_ld_ready", 16'(ld_ready), 16'h0);
        chk("midrst_mdrout", 16'(MDROut), 16'h000);
        rst = 1'b0; ld_data = 10'h001; ld_last = 1'b1;
        #1;
        chk("midrst_reload_ready", 16'(ld_ready), 16'h1);
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        MAR = 6'd0; tick();
        chk("midrst_cpu_run", 16'(cpu_rst), 16'h0);
        chk("midrst_mem0", 16'(MDROut), 16'h001);
        MAR = 6'd1; tick(); chk("midrst_mem1", 16'(MDROut), 16'h0A2);
        MAR = 6'd2; tick(); chk("midrst_mem2_untouched", 16'(MDROut), 16'h202);
        MAR = 6'd3; tick(); chk("midrst_mem3", 16'(MDROut), 16'h203);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
